// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side pointer and flag controller for a dual-clock FIFO
// Ports:
//   rd_clk_i        read-domain clock
//   rst_i           synchronous active-high reset
//   rd_en_i         read request (ignored while empty, flagged as underflow)
//   flush_i         discard all stored entries (read pointer jumps to write pointer)
//   wr_gptr_i       Gray write pointer, already synchronised into rd_clk_i
//   rd_addr_o       RAM read address
//   rd_gptr_o       Gray read pointer for the write domain
//   empty_o         FIFO empty
//   almost_empty_o  occupancy <= AE_LEVEL
//   rd_level_o      occupancy seen from the read side
//   rd_valid_o      RAM read data valid (one cycle after an accepted read)
//   underflow_o     sticky read-while-empty flag
module fifo_rd_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int AE_LEVEL = 2
) (
    input  logic              rd_clk_i,
    input  logic              rst_i,
    input  logic              rd_en_i,
    input  logic              flush_i,
    input  logic [ADDR_W:0]   wr_gptr_i,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W:0]   rd_gptr_o,
    output logic              empty_o,
    output logic              almost_empty_o,
    output logic [ADDR_W:0]   rd_level_o,
    output logic              rd_valid_o,
    output logic              underflow_o
);
    localparam logic [ADDR_W:0] AE_L = AE_LEVEL[ADDR_W:0];

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [ADDR_W:0] rd_bin_q, rd_bin_d;
    logic [ADDR_W:0] rd_gptr_q, level_d, wr_bin;
    logic [ADDR_W:0] level_q;
    logic            empty_q, ae_q, valid_q, uflow_q, rd_fire;

    always_comb begin
        wr_bin   = gray2bin(wr_gptr_i);
        rd_fire  = rd_en_i & ~empty_q;
        rd_bin_d = rd_bin_q + {{ADDR_W{1'b0}}, rd_fire};
        level_d  = wr_bin - rd_bin_d;
    end

    always_ff @(posedge rd_clk_i) begin
        if (rst_i) begin
            rd_bin_q  <= '0;
            rd_gptr_q <= '0;
            empty_q   <= 1'b1;
            ae_q      <= 1'b1;
            level_q   <= '0;
            valid_q   <= 1'b0;
            uflow_q   <= 1'b0;
        end else if (flush_i) begin
            rd_bin_q  <= wr_bin;
            rd_gptr_q <= wr_gptr_i;
            empty_q   <= 1'b1;
            ae_q      <= 1'b1;
            level_q   <= '0;
            valid_q   <= 1'b0;
            uflow_q   <= 1'b0;
        end else begin
            rd_bin_q  <= rd_bin_d;
            rd_gptr_q <= bin2gray(rd_bin_d);
            // Gray compare keeps empty exact even if level_d is corrupted by a bad write side
            empty_q   <= bin2gray(rd_bin_d) == wr_gptr_i;
            ae_q      <= level_d <= AE_L;
            level_q   <= level_d;
            valid_q   <= rd_fire;
            uflow_q   <= uflow_q | (rd_en_i & empty_q);
        end
    end

    assign rd_addr_o      = rd_bin_q[ADDR_W-1:0];
    assign rd_gptr_o      = rd_gptr_q;
    assign empty_o        = empty_q;
    assign almost_empty_o = ae_q;
    assign rd_level_o     = level_q;
    assign rd_valid_o     = valid_q;
    assign underflow_o    = uflow_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: self-checking bench for fifo_rd_ctrl (ADDR_W=3, AE_LEVEL=2)
module tb_fifo_rd_ctrl;
    localparam int AW = 3;
    localparam int AE = 2;
    localparam int DEPTH = 1 << AW;
    localparam int MOD = 2 * DEPTH;

    logic          clk = 1'b0;
    logic          rst, rd_en, flush;
    logic [AW:0]   wg;
    logic [AW-1:0] addr;
    logic [AW:0]   gptr, level;
    logic          empty, ae, valid, uf;

    int n_chk = 0;
    int n_err = 0;

    // model: pointers as plain counts modulo 2*DEPTH
    int m_rd, m_level;
    bit m_empty, m_ae, m_valid, m_uf;

    fifo_rd_ctrl #(.ADDR_W(AW), .AE_LEVEL(AE)) dut (
        .rd_clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .flush_i(flush),
        .wr_gptr_i(wg), .rd_addr_o(addr), .rd_gptr_o(gptr), .empty_o(empty),
        .almost_empty_o(ae), .rd_level_o(level), .rd_valid_o(valid), .underflow_o(uf)
    );

    always #5 clk = ~clk;

    function automatic logic [AW:0] gray(input int b);
        int x;
        x = b % MOD;
        return 4'(x ^ (x >> 1));
    endfunction

    function automatic int g2b(input logic [AW:0] g);
        for (int k = 0; k < MOD; k++) if (gray(k) == g) return k;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int wb;
        bit fire;
        wb = g2b(wg);
        if (rst) begin
            m_rd = 0; m_empty = 1; m_ae = 1; m_level = 0; m_valid = 0; m_uf = 0;
        end else if (flush) begin
            m_rd = wb; m_empty = 1; m_ae = 1; m_level = 0; m_valid = 0; m_uf = 0;
        end else begin
            fire = rd_en && !m_empty;
            if (rd_en && m_empty) m_uf = 1;
            m_valid = fire;
            m_rd = (m_rd + int'(fire)) % MOD;
            m_level = (wb - m_rd + MOD) % MOD;
            m_empty = m_level == 0;
            m_ae = m_level <= AE;
        end
    endtask

    task automatic cyc(input bit r, input bit f, input bit re, input logic [AW:0] w);
        rst = r; flush = f; rd_en = re; wg = w;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".addr"}, int'(addr), m_rd % DEPTH);
        chk({tag, ".gptr"}, int'(gptr), int'(gray(m_rd)));
        chk({tag, ".empty"}, int'(empty), int'(m_empty));
        chk({tag, ".ae"}, int'(ae), int'(m_ae));
        chk({tag, ".level"}, int'(level), m_level);
        chk({tag, ".valid"}, int'(valid), int'(m_valid));
        chk({tag, ".uf"}, int'(uf), int'(m_uf));
    endtask

    typedef struct {
        bit          r, f, re;
        logic [AW:0] w;
        int          e_addr, e_gptr, e_empty, e_ae, e_level, e_valid, e_uf;
    } vec_t;

    vec_t vec[7];

    initial begin
        int wcnt, gstep[4], astep[4];
        rst = 1; flush = 0; rd_en = 0; wg = '0;
        m_rd = 0; m_level = 0; m_empty = 1; m_ae = 1; m_valid = 0; m_uf = 0;

        // reset, then three entries read back-to-back
        vec[0] = '{1, 0, 0, 4'b0000, 0, 0, 1, 1, 0, 0, 0};
        vec[1] = '{0, 0, 0, 4'b0000, 0, 0, 1, 1, 0, 0, 0};
        vec[2] = '{0, 0, 0, 4'b0010, 0, 0, 0, 0, 3, 0, 0};
        vec[3] = '{0, 0, 1, 4'b0010, 1, 1, 0, 1, 2, 1, 0};
        vec[4] = '{0, 0, 1, 4'b0010, 2, 3, 0, 1, 1, 1, 0};
        vec[5] = '{0, 0, 1, 4'b0010, 3, 2, 1, 1, 0, 1, 0};
        vec[6] = '{0, 0, 0, 4'b0010, 3, 2, 1, 1, 0, 0, 0};
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            cyc(vec[i].r, vec[i].f, vec[i].re, vec[i].w);
            chk($sformatf("vec%0d.addr", i), int'(addr), vec[i].e_addr);
            chk($sformatf("vec%0d.gptr", i), int'(gptr), vec[i].e_gptr);
            chk($sformatf("vec%0d.empty", i), int'(empty), vec[i].e_empty);
            chk($sformatf("vec%0d.ae", i), int'(ae), vec[i].e_ae);
            chk($sformatf("vec%0d.level", i), int'(level), vec[i].e_level);
            chk($sformatf("vec%0d.valid", i), int'(valid), vec[i].e_valid);
            chk($sformatf("vec%0d.uf", i), int'(uf), vec[i].e_uf);
        end

        // wrap: preset read pointer to 14, four entries across the rollover
        cyc(0, 1, 0, 4'b1001);
        chk("wrap.preset_gptr", int'(gptr), 9);
        chk("wrap.preset_addr", int'(addr), 6);
        cyc(0, 0, 0, 4'b0011);
        chk("wrap.level", int'(level), 4);
        astep = '{6, 7, 0, 1};
        gstep = '{9, 8, 0, 1};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wrap.addr%0d", i), int'(addr), astep[i]);
            chk($sformatf("wrap.gptr%0d", i), int'(gptr), gstep[i]);
            cyc(0, 0, 1, 4'b0011);
            chk_model("wrap");
        end
        chk("wrap.empty_end", int'(empty), 1);

        // underflow: read while empty, then idle
        cyc(0, 0, 1, 4'b0011);
        chk("uf.addr_hold", int'(addr), 2);
        chk("uf.valid", int'(valid), 0);
        chk("uf.set", int'(uf), 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 4'b0011);
        chk("uf.sticky", int'(uf), 1);
        chk_model("uf");

        // flush with a read pending at level 5
        cyc(0, 0, 0, gray(7));
        chk("fl.level5", int'(level), 5);
        cyc(0, 1, 1, gray(7));
        chk("fl.gptr", int'(gptr), int'(gray(7)));
        chk("fl.empty", int'(empty), 1);
        chk("fl.level", int'(level), 0);
        chk("fl.valid", int'(valid), 0);
        chk("fl.uf", int'(uf), 0);

        // full occupancy, then read with simultaneous write advance
        cyc(1, 0, 0, 4'b0000);
        cyc(0, 0, 0, 4'b1100);
        chk("full.level", int'(level), 8);
        chk("full.empty", int'(empty), 0);
        chk("full.ae", int'(ae), 0);
        cyc(0, 0, 1, 4'b1101);
        chk("full.rdwr_level", int'(level), 8);
        chk_model("full");

        // randomized traffic against the model, write side kept legal
        wcnt = 9;
        for (int i = 0; i < 3000; i++) begin
            bit r, f, re;
            int room;
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 59) == 0);
            re = ($urandom_range(0, 99) < 55);
            room = DEPTH - ((wcnt - m_rd + MOD) % MOD);
            if (room > 0 && $urandom_range(0, 99) < 50) wcnt += $urandom_range(1, room);
            wcnt %= MOD;
            cyc(r, f, re, gray(wcnt));
            if (r) begin
                wcnt = 0;
                cyc(0, 0, 0, gray(0));
            end
            chk_model("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, FIFO address width; depth DEPTH = 2^ADDR_W.
REQ-002 Parameter AE_LEVEL, default 2, almost-empty threshold in entries, range 0..DEPTH-1.
REQ-003 Clocking: one clock, rd_clk_i; reset rst_i is synchronous and active-high.
REQ-004 rd_clk_i  input  1  read-domain clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  synchronous active-high reset.
REQ-006 rd_en_i  input  1  read request.
REQ-007 flush_i  input  1  synchronous discard of all stored entries.
REQ-008 wr_gptr_i  input  ADDR_W+1  write pointer, Gray-coded, already synchronised into rd_clk_i.
REQ-009 rd_addr_o  output  ADDR_W  RAM read address.
REQ-010 rd_gptr_o  output  ADDR_W+1  registered Gray-coded read pointer, for export to the write domain.
REQ-011 empty_o  output  1  FIFO empty, registered.
REQ-012 almost_empty_o  output  1  level <= AE_LEVEL, registered.
REQ-013 rd_level_o  output  ADDR_W+1  occupancy seen from the read side, 0..DEPTH.
REQ-014 rd_valid_o  output  1  RAM read data valid this cycle.
REQ-015 underflow_o  output  1  sticky underflow flag.

Function
REQ-016 Internal binary pointer rd_bin[ADDR_W:0]; rd_fire = rd_en_i & ~empty_o; rd_bin_next = rd_bin + rd_fire, modulo 2^(ADDR_W+1).
REQ-017 rd_addr_o = rd_bin[ADDR_W-1:0], driven directly from the register with no combinational path from rd_en_i.
REQ-018 rd_gptr_o is registered as bin2gray(rd_bin_next) = rd_bin_next ^ (rd_bin_next >> 1), so it always equals the Gray code of rd_bin.
REQ-019 wr_bin = gray2bin(wr_gptr_i), combinational, prefix XOR from the MSB.
REQ-020 empty_o is registered as (bin2gray(rd_bin_next) == wr_gptr_i); a read of the last entry asserts empty_o on the following edge.
REQ-021 rd_level_o is registered as (wr_bin - rd_bin_next) modulo 2^(ADDR_W+1); a value > DEPTH is a write-side protocol error and is not corrected.
REQ-022 almost_empty_o is registered as (level_next <= AE_LEVEL), evaluated in the same cycle as rd_level_o.
REQ-023 rd_valid_o equals rd_fire delayed by one cycle (synchronous RAM read latency 1).
REQ-024 rd_en_i while empty_o = 1: rd_bin, rd_addr_o and rd_gptr_o hold, rd_valid_o = 0 next cycle, and underflow_o sets next cycle.
REQ-025 underflow_o, once set, holds until rst_i or flush_i.
REQ-026 flush_i = 1: next edge sets rd_bin = wr_bin, rd_gptr_o = wr_gptr_i, empty_o = 1, almost_empty_o = 1, rd_level_o = 0, rd_valid_o = 0, underflow_o = 0.
REQ-027 Priority order: rst_i, then flush_i, then rd_en_i.
REQ-028 Wrap-around: rd_bin rolls over from 2^(ADDR_W+1)-1 to 0, rd_addr_o rolls over from DEPTH-1 to 0, and Gray single-bit-change holds across the wrap.
REQ-029 A read and a wr_gptr_i advance in the same cycle: level_next = wr_bin - rd_bin_next; both events are reflected in the registered flags.
REQ-030 Full occupancy (wr_bin - rd_bin = DEPTH): rd_level_o = DEPTH, empty_o = 0, almost_empty_o = 0 when AE_LEVEL < DEPTH.

Reset
REQ-031 While rst_i = 1 at an edge: rd_bin = 0, rd_addr_o = 0, rd_gptr_o = 0, empty_o = 1, almost_empty_o = 1, rd_level_o = 0, rd_valid_o = 0, underflow_o = 0.
REQ-032 Reset asserted mid-read overrides rd_en_i and flush_i; flags are re-evaluated against wr_gptr_i from the first edge after release.

Verification (ADDR_W=3, AE_LEVEL=2)
REQ-033 Reset with wr_gptr_i = 0 -> all outputs at REQ-031 values; empty_o stays 1 after release.
REQ-034 wr_gptr_i = gray(3) = 4'b0010, then rd_en_i high for 3 cycles:
- next edge: empty_o = 0, rd_level_o = 3, almost_empty_o = 0;
- rd_addr_o steps 0, 1, 2; rd_valid_o is 1 for 3 cycles, each one cycle late;
- after the third read: empty_o = 1, rd_level_o = 0;
- after the second read: almost_empty_o = 1 (level 1).
REQ-035 Wrap: preset rd_bin = 14 via flush with wr_gptr_i = gray(14), then wr_gptr_i = gray(2), read 4 entries:
- rd_addr_o steps 6, 7, 0, 1;
- rd_gptr_o steps 4'b1001, 4'b1000, 4'b0000, 4'b0001;
- empty_o = 1 at end.
REQ-036 rd_en_i = 1 while empty_o = 1 -> rd_addr_o unchanged, rd_valid_o = 0, underflow_o = 1 next cycle and still 1 after 10 idle cycles.
REQ-037 Level 5 plus flush_i with rd_en_i = 1 -> next edge: rd_gptr_o = wr_gptr_i, empty_o = 1, rd_level_o = 0, rd_valid_o = 0, underflow_o = 0.
REQ-038 Full: rd_bin = 0, wr_gptr_i = gray(8) = 4'b1100 -> rd_level_o = 8, empty_o = 0, almost_empty_o = 0; a read plus simultaneous wr_gptr_i = gray(9) keeps rd_level_o = 8.
